// File: rtl/axis_frame_len_guard_pkg.sv
// Shared definitions for the AXI4-Stream frame length guard.
//   state_t      : guard FSM encoding (PASS forwards beats, DISCARD drops a truncated tail)
//   BAD_BIT      : tuser bit that marks a frame for downstream drop
//   cnt_width()  : byte counter width able to hold 0..max_len
package axis_frame_len_guard_pkg;

   typedef enum logic {
      ST_PASS    = 1'b0,
      ST_DISCARD = 1'b1
   } state_t;

   localparam int BAD_BIT = 0;

   function automatic int cnt_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/axis_frame_len_guard_if.sv
// AXI4-Stream byte channel bundle.
//   tdata/tvalid/tlast/tuser : source -> sink
//   tready                   : sink -> source
//   modport master : the driving side, modport slave : the receiving side
interface axis_frame_len_guard_if #(
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 1
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_pipe_reg.sv
// Single-stage AXI4-Stream register (data/last/user with valid/ready).
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : load handshake; in_ready = !out_valid | out_ready
//   in_data/last/user : beat to capture
//   out_*             : registered beat; held stable while out_valid & !out_ready
module axis_pipe_reg #(
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   input  logic [USER_WIDTH-1:0] in_user,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic [USER_WIDTH-1:0] out_user
);

   assign in_ready = !out_valid | out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_user  <= '0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
         out_last  <= in_last;
         out_user  <= in_user;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_frame_len_guard.sv
// AXI4-Stream frame length guard (8-bit byte stream).
// Counts bytes per frame, truncates frames longer than MAX_LEN and marks them bad
// through tuser[BAD_BIT], and marks runts shorter than MIN_LEN bad as well.
//   clk, rst        : sole clock, asynchronous active-high reset
//   s_axis (slave)  : input stream; tuser[0] = upstream error
//   m_axis (master) : registered output stream; tuser[0] = bad frame
//   status_oversize : one-cycle pulse when a frame is truncated
//   status_runt     : one-cycle pulse when a runt last beat is accepted
//   status_good     : one-cycle pulse when a frame passes unmarked
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_PASS    | beats forwarded to the output register, bytes counted
// ST_DISCARD | frame was cut at MAX_LEN; remaining beats dropped until tlast
module axis_frame_len_guard
   import axis_frame_len_guard_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LEN    = 1518,
   parameter int MIN_LEN    = 60,
   parameter int USER_WIDTH = 1,
   parameter int CNT_WIDTH  = cnt_width(MAX_LEN)
) (
   input  logic                   clk,
   input  logic                   rst,
   axis_frame_len_guard_if.slave  s_axis,
   axis_frame_len_guard_if.master m_axis,
   output logic                   status_oversize,
   output logic                   status_runt,
   output logic                   status_good
);

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   count_q, count_d;
   logic [CNT_WIDTH-1:0]   cnt_inc;

   logic                   pipe_in_valid, pipe_in_ready;
   logic [DATA_WIDTH-1:0]  d_data;
   logic                   d_last;
   logic [USER_WIDTH-1:0]  d_user;
   logic                   is_runt;
   logic                   over_d, runt_d, good_d;

   // count never exceeds MAX_LEN-1 between beats, so the increment always fits.
   assign cnt_inc = count_q + 1'b1;

   assign s_axis.tready = (state_q == ST_DISCARD) | pipe_in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_PASS;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      pipe_in_valid = 1'b0;
      d_data        = s_axis.tdata;
      d_last        = s_axis.tlast;
      d_user        = s_axis.tuser;
      is_runt       = 1'b0;
      over_d        = 1'b0;
      runt_d        = 1'b0;
      good_d        = 1'b0;

      case (state_q)
         ST_PASS: begin
            pipe_in_valid = s_axis.tvalid;
            if (s_axis.tvalid && pipe_in_ready) begin
               if (s_axis.tlast) begin
                  // A last beat landing exactly on MAX_LEN is a legal full-size frame.
                  is_runt         = (cnt_inc < CNT_WIDTH'(MIN_LEN));
                  d_user[BAD_BIT] = s_axis.tuser[BAD_BIT] | is_runt;
                  runt_d          = is_runt;
                  good_d          = !(s_axis.tuser[BAD_BIT] | is_runt);
                  count_d         = '0;
               end else if (cnt_inc == CNT_WIDTH'(MAX_LEN)) begin
                  d_last          = 1'b1;
                  d_user[BAD_BIT] = 1'b1;
                  over_d          = 1'b1;
                  count_d         = '0;
                  state_d         = ST_DISCARD;
               end else begin
                  count_d         = cnt_inc;
               end
            end
         end
         ST_DISCARD: begin
            if (s_axis.tvalid && s_axis.tlast) begin
               state_d = ST_PASS;
            end
         end
         default: state_d = ST_PASS;
      endcase
   end

   // Pulses line up with the output beat they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_oversize <= 1'b0;
         status_runt     <= 1'b0;
         status_good     <= 1'b0;
      end else begin
         status_oversize <= over_d;
         status_runt     <= runt_d;
         status_good     <= good_d;
      end
   end

   axis_pipe_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .USER_WIDTH (USER_WIDTH)
   ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (pipe_in_valid),
      .in_ready  (pipe_in_ready),
      .in_data   (d_data),
      .in_last   (d_last),
      .in_user   (d_user),
      .out_valid (m_axis.tvalid),
      .out_ready (m_axis.tready),
      .out_data  (m_axis.tdata),
      .out_last  (m_axis.tlast),
      .out_user  (m_axis.tuser)
   );

endmodule

// File: tb/tb_axis_frame_len_guard.sv
module tb_axis_frame_len_guard;

   localparam int MAX_LEN = 1518;
   localparam int MIN_LEN = 60;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic status_oversize, status_runt, status_good;

   int total = 0;
   int bad   = 0;
   int n_good = 0, n_runt = 0, n_over = 0;
   int cyc = 0;
   bit bp_en = 1'b0;

   logic [9:0] exp_q[$];
   logic [9:0] out_q[$];
   int         xfer_cyc[$];
   bit         prev_stall = 1'b0;
   logic [10:0] prev_out = '0;

   axis_frame_len_guard_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) s_if ();
   axis_frame_len_guard_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) m_if ();

   axis_frame_len_guard #(
      .DATA_WIDTH (8),
      .MAX_LEN    (MAX_LEN),
      .MIN_LEN    (MIN_LEN),
      .USER_WIDTH (1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .s_axis          (s_if),
      .m_axis          (m_if),
      .status_oversize (status_oversize),
      .status_runt     (status_runt),
      .status_good     (status_good)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Output monitor: transfers, status pulses, and hold-while-stalled.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("stall_hold", {21'd0, m_if.tvalid, m_if.tuser[0], m_if.tlast, m_if.tdata},
                {21'd0, prev_out});
         prev_stall = m_if.tvalid && !m_if.tready;
         prev_out   = {m_if.tvalid, m_if.tuser[0], m_if.tlast, m_if.tdata};
         if (m_if.tvalid && m_if.tready) begin
            out_q.push_back({m_if.tuser[0], m_if.tlast, m_if.tdata});
            xfer_cyc.push_back(cyc);
         end
         if (status_good)     n_good++;
         if (status_runt)     n_runt++;
         if (status_oversize) n_over++;
      end
   end

   // Output backpressure source.
   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic clear_stats();
      n_good = 0;
      n_runt = 0;
      n_over = 0;
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
      bit ok;
      ok = 1'b0;
      s_if.tdata  = d;
      s_if.tlast  = l;
      s_if.tuser  = u;
      s_if.tvalid = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (s_if.tready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Expected output of a frame: truncated to MAX_LEN with the cut beat marked;
   // otherwise the last beat is marked for runts or an upstream error.
   task automatic send_frame(input int len, input logic [7:0] base, input logic user_last);
      int   n;
      logic l, u;
      n = (len > MAX_LEN) ? MAX_LEN : len;
      for (int i = 0; i < n; i++) begin
         l = (i == n - 1);
         u = l && ((len > MAX_LEN) || user_last || (len < MIN_LEN));
         exp_q.push_back({u, l, 8'(base + 8'(i))});
      end
      for (int i = 0; i < len; i++)
         send_beat(8'(base + 8'(i)), (i == len - 1), (i == len - 1) && user_last);
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
   endtask

   task automatic check_frames(input string tag);
      int mism;
      for (int k = 0; k < 20000; k++) begin
         @(negedge clk);
         if (out_q.size() >= exp_q.size()) break;
      end
      repeat (4) @(negedge clk);
      chk({tag, "_count"}, out_q.size(), exp_q.size());
      mism = 0;
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         if (out_q[i] !== exp_q[i]) mism++;
      chk({tag, "_data"}, mism, 0);
      exp_q.delete();
      out_q.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      s_if.tdata  = '0;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = '0;

      // reset values
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_tvalid", m_if.tvalid, 1'b0);
      chk("rst_m_tlast",  m_if.tlast,  1'b0);
      chk("rst_m_tdata",  m_if.tdata,  8'h00);
      chk("rst_m_tuser",  m_if.tuser,  1'b0);
      chk("rst_status",   {status_oversize, status_runt, status_good}, 3'b000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rel_s_tready", s_if.tready, 1'b1);
      @(posedge clk);
      #1;

      // 64-byte good frame, no bubbles
      clear_stats();
      xfer_cyc.delete();
      send_frame(64, 8'h00, 1'b0);
      check_frames("f64");
      chk("f64_span", (xfer_cyc.size() >= 64) ? (xfer_cyc[63] - xfer_cyc[0]) : -1, 63);
      chk("f64_good", n_good, 1);
      chk("f64_runt", n_runt, 0);
      chk("f64_over", n_over, 0);

      // 1520-byte frame truncated, next frame intact
      clear_stats();
      send_frame(1520, 8'h10, 1'b0);
      send_frame(64, 8'h80, 1'b0);
      check_frames("trunc");
      chk("trunc_over", n_over, 1);
      chk("trunc_good", n_good, 1);
      chk("trunc_runt", n_runt, 0);

      // exactly MAX_LEN is good; MAX_LEN+1 is cut
      clear_stats();
      send_frame(1518, 8'h20, 1'b0);
      check_frames("max");
      chk("max_good", n_good, 1);
      chk("max_over", n_over, 0);
      clear_stats();
      send_frame(1519, 8'h30, 1'b0);
      check_frames("max1");
      chk("max1_over", n_over, 1);
      chk("max1_good", n_good, 0);

      // runts and upstream error
      clear_stats();
      send_frame(10, 8'h40, 1'b0);
      send_frame(1, 8'h50, 1'b0);
      check_frames("runt");
      chk("runt_cnt",  n_runt, 2);
      chk("runt_good", n_good, 0);
      clear_stats();
      send_frame(60, 8'h60, 1'b1);
      send_frame(60, 8'h70, 1'b0);
      check_frames("uerr");
      chk("uerr_good", n_good, 1);
      chk("uerr_runt", n_runt, 0);

      // random backpressure across back-to-back frames
      bp_en = 1'b1;
      clear_stats();
      send_frame(64, 8'h01, 1'b0);
      send_frame(10, 8'h02, 1'b0);
      send_frame(1520, 8'h03, 1'b0);
      send_frame(100, 8'h04, 1'b0);
      send_frame(60, 8'h05, 1'b1);
      send_frame(1518, 8'h06, 1'b0);
      check_frames("bp");
      chk("bp_good", n_good, 3);
      chk("bp_runt", n_runt, 1);
      chk("bp_over", n_over, 1);
      bp_en = 1'b0;
      @(posedge clk);
      #1;

      // reset at byte 30 of a frame
      for (int i = 0; i < 30; i++) send_beat(8'(i), 1'b0, 1'b0);
      chk("prerst_tvalid", m_if.tvalid, 1'b1);
      rst = 1'b1;
      s_if.tvalid = 1'b0;
      #1;
      chk("midrst_tvalid", m_if.tvalid, 1'b0);
      chk("midrst_tdata",  m_if.tdata,  8'h00);
      chk("midrst_tlast",  m_if.tlast,  1'b0);
      chk("midrst_status", {status_oversize, status_runt, status_good}, 3'b000);
      exp_q.delete();
      out_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_stats();
      send_frame(64, 8'h90, 1'b0);
      send_frame(1500, 8'hA0, 1'b0);
      check_frames("postrst");
      chk("postrst_good", n_good, 2);
      chk("postrst_over", n_over, 0);
      chk("postrst_runt", n_runt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
